// File: rtl/bus_master_if.sv
// -----------------------------------------------------------------------------
// bus_master_if
//
// Requester endpoint of the shared round-robin CPU bus. It takes single-word
// read/write commands from a local core, requests the bus, drives one
// address-strobe cycle once granted, waits for the slave ready, and then
// returns read data together with a one-cycle done pulse. m_req is held for
// the whole transaction, so the arbiter keeps this master granted until the
// transfer completes.
//
// Optional feature macro: BUS_TIMEOUT_EN
//   defined   : an 8-bit ready timer runs in ACCESS/WAIT. If s_rdy has not
//               arrived when it reaches TIMEOUT_CYCLES-1, the transaction ends
//               with cpu_done=1 and cpu_err=1.
//   undefined : no timer, WAIT lasts until s_rdy, and cpu_err is tied to 0.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   cpu_req      in   command valid (level), taken only while cpu_busy=0
//   cpu_addr     in   command word address
//   cpu_rw       in   1=read, 0=write
//   cpu_wr_data  in   write data
//   cpu_busy     out  high from the cycle after acceptance until cpu_done
//   cpu_done     out  one-cycle completion pulse
//   cpu_rd_data  out  read data, held until the next read completes
//   cpu_err      out  timeout flag, qualified by cpu_done
//   m_req        out  bus request to the arbiter
//   m_grnt       in   bus grant from the arbiter
//   m_as         out  address strobe, one cycle per transaction
//   m_addr       out  bus address (0 while idle)
//   m_rw         out  bus read/write, 1=read (0 while idle)
//   m_wr_data    out  bus write data (0 while idle)
//   s_rd_data    in   read data from the selected slave
//   s_rdy        in   slave ready / transfer complete
// -----------------------------------------------------------------------------
// state  | meaning
// IDLE   | no command; bus outputs forced to 0; new command accepted here
// REQ    | command latched, m_req high, waiting for m_grnt
// ACCESS | single m_as cycle, command driven on the bus
// WAIT   | strobe done, bus held, waiting for s_rdy
// -----------------------------------------------------------------------------
module bus_master_if #(
  parameter int ADDR_W         = 30,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_rw,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic              cpu_busy,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic              cpu_err,
  output logic              m_req,
  input  logic              m_grnt,
  output logic              m_as,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_rw,
  output logic [DATA_W-1:0] m_wr_data,
  input  logic [DATA_W-1:0] s_rd_data,
  input  logic              s_rdy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACCESS = 2'd2,
    WAIT   = 2'd3
  } state_t;

  state_t state;
  logic   tmo_hit;

  generate
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("bus_master_if: TIMEOUT_CYCLES must lie in 2..255");
    end
  endgenerate

`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt;

  assign tmo_hit = (tmo_cnt == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
  assign cpu_err = 1'b0;
`endif

  // The m_addr/m_rw/m_wr_data registers double as the command registers:
  // they are loaded on acceptance and cleared on completion, which also
  // keeps an idle master from disturbing the OR/mux bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cpu_busy    <= 1'b0;
      cpu_done    <= 1'b0;
      cpu_rd_data <= '0;
      m_req       <= 1'b0;
      m_as        <= 1'b0;
      m_addr      <= '0;
      m_rw        <= 1'b0;
      m_wr_data   <= '0;
`ifdef BUS_TIMEOUT_EN
      cpu_err     <= 1'b0;
      tmo_cnt     <= '0;
`endif
    end else begin
      cpu_done <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      cpu_err  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // cpu_busy is always 0 here, so the command is taken as is,
          // including one presented in the cpu_done cycle.
          if (cpu_req) begin
            state     <= REQ;
            cpu_busy  <= 1'b1;
            m_req     <= 1'b1;
            m_addr    <= cpu_addr;
            m_rw      <= cpu_rw;
            m_wr_data <= cpu_wr_data;
          end
        end

        REQ: begin
          // Grant wait is untimed; s_rdy is meaningless here.
          if (m_grnt) begin
            state <= ACCESS;
            m_as  <= 1'b1;
`ifdef BUS_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end
        end

        ACCESS, WAIT: begin
          // The grant is not rechecked: the arbiter never revokes it
          // while m_req is held.
          m_as <= 1'b0;
`ifdef BUS_TIMEOUT_EN
          tmo_cnt <= tmo_cnt + 8'd1;
`endif
          if (s_rdy || tmo_hit) begin
            state     <= IDLE;
            cpu_done  <= 1'b1;
            cpu_busy  <= 1'b0;
            m_req     <= 1'b0;
            m_addr    <= '0;
            m_rw      <= 1'b0;
            m_wr_data <= '0;
            // A ready arriving together with the timeout wins.
            if (s_rdy && m_rw) begin
              cpu_rd_data <= s_rd_data;
            end
`ifdef BUS_TIMEOUT_EN
            if (!s_rdy) begin
              cpu_err <= 1'b1;
            end
`endif
          end else begin
            state <= WAIT;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_if.sv
module tb_bus_master_if;
  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int TMO    = 16;
`ifdef BUS_TIMEOUT_EN
  localparam int RDL_MAX = TMO - 1;
`else
  localparam int RDL_MAX = 20;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_rw;
  logic [DATA_W-1:0] cpu_wr_data;
  logic              cpu_busy;
  logic              cpu_done;
  logic [DATA_W-1:0] cpu_rd_data;
  logic              cpu_err;
  logic              m_req;
  logic              m_grnt;
  logic              m_as;
  logic [ADDR_W-1:0] m_addr;
  logic              m_rw;
  logic [DATA_W-1:0] m_wr_data;
  logic [DATA_W-1:0] s_rd_data;
  logic              s_rdy;

  always #5 clk = ~clk;

  bus_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw), .cpu_wr_data(cpu_wr_data),
    .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_rd_data(cpu_rd_data), .cpu_err(cpu_err),
    .m_req(m_req), .m_grnt(m_grnt), .m_as(m_as), .m_addr(m_addr), .m_rw(m_rw),
    .m_wr_data(m_wr_data), .s_rd_data(s_rd_data), .s_rdy(s_rdy)
  );

  // req_len: number of cycles m_req waits in REQ (grant seen in the last one)
  // rdl: cycles between the strobe cycle and the s_rdy cycle
  // lat: expected acceptance-to-done distance in cycles
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              rw;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] rd;
    int                req_len;
    int                rdl;
    int                lat;
    logic [DATA_W-1:0] exp_rd;
    bit                noise;
  } vec_t;

  int tests = 0;
  int fails = 0;
  logic [DATA_W-1:0] model_rd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Entered just after a falling edge with the DUT idle. Cycle k is the k-th
  // cycle after the acceptance edge; inputs for cycle k are driven at its
  // falling edge right after its outputs have been sampled.
  task automatic do_txn(input vec_t v, input bit tmo, input string tag);
    int done_k = 0, as_cnt = 0, as_k = 0, req_cnt = 0, busy_bad = 0, bus_bad = 0;
    int rdy_k;
    bit seen = 0;
    logic err_d = 1'b1, busy_d = 1'b1, req_d = 1'b1;
    logic [ADDR_W-1:0] addr_d = '1;
    logic [DATA_W-1:0] rd_d = '0;
    rdy_k = v.req_len + 1 + v.rdl;
    cpu_req = 1'b1; cpu_addr = v.addr; cpu_rw = v.rw; cpu_wr_data = v.wd;
    m_grnt = 1'b0; s_rdy = 1'b0; s_rd_data = $urandom;
    for (int k = 1; k <= v.lat + 10; k++) begin
      @(negedge clk);
      if (cpu_done) begin
        seen = 1; done_k = k; err_d = cpu_err; busy_d = cpu_busy;
        req_d = m_req; addr_d = m_addr; rd_d = cpu_rd_data;
      end else begin
        if (m_req) req_cnt++;
        if (m_as) begin as_cnt++; as_k = k; end
        if (!cpu_busy) busy_bad++;
        if (m_addr !== v.addr || m_rw !== v.rw || m_wr_data !== v.wd) bus_bad++;
      end
      cpu_req = 1'b0; cpu_addr = ADDR_W'($urandom); cpu_rw = 1'($urandom);
      cpu_wr_data = $urandom; s_rd_data = $urandom;
      if (seen) begin m_grnt = 1'b0; s_rdy = 1'b0; break; end
      if (v.noise && k < v.lat) cpu_req = 1'($urandom);
      m_grnt = (k >= v.req_len);
      if (v.noise && k > v.req_len) m_grnt = 1'($urandom);
      s_rdy = (!tmo && k == rdy_k);
      if (s_rdy) s_rd_data = v.rd;
      if (v.noise && k <= v.req_len) s_rdy = 1'($urandom);
    end
    check({tag, " done_seen"}, 64'(seen), 64'(1));
    check({tag, " latency"}, 64'(done_k), 64'(v.lat));
    check({tag, " as_count"}, 64'(as_cnt), 64'(1));
    check({tag, " as_cycle"}, 64'(as_k), 64'(v.req_len + 1));
    check({tag, " req_cycles"}, 64'(req_cnt), 64'(v.lat - 1));
    check({tag, " busy_low_early"}, 64'(busy_bad), 64'(0));
    check({tag, " bus_unstable"}, 64'(bus_bad), 64'(0));
    check({tag, " err"}, 64'(err_d), 64'(tmo));
    check({tag, " busy_at_done"}, 64'(busy_d), 64'(0));
    check({tag, " req_at_done"}, 64'(req_d), 64'(0));
    check({tag, " addr_at_done"}, 64'(addr_d), 64'(0));
    check({tag, " rd_data"}, 64'(rd_d), 64'(v.exp_rd));
    // Idle cycle: a stray s_rdy here must be ignored.
    s_rdy = v.noise;
    @(negedge clk);
    check({tag, " after_done"}, 64'({cpu_done, cpu_busy, m_req, m_as}), 64'(0));
    s_rdy = 1'b0;
  endtask

  vec_t tbl[5];
  vec_t v;
  logic [6:0] req_bits, done_bits;
  logic [ADDR_W-1:0] a1, a2;
  logic [DATA_W-1:0] r1, r2;
  bit tmo;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{30'h10,       1'b1, 32'h0,        32'hDEADBEEF, 1, 0, 3, 32'hDEADBEEF, 1'b0};
    tbl[1] = '{30'h2A,       1'b0, 32'h12345678, 32'hBAD0BAD0, 4, 2, 8, 32'hDEADBEEF, 1'b1};
    tbl[2] = '{30'h3FFFFFFF, 1'b1, 32'h0,        32'h00000001, 1, 5, 8, 32'h00000001, 1'b0};
    tbl[3] = '{30'h0,        1'b0, 32'hFFFFFFFF, 32'h55555555, 2, 0, 4, 32'h00000001, 1'b0};
    tbl[4] = '{30'h155,      1'b1, 32'h0,        32'hA5A5A5A5, 3, 1, 6, 32'hA5A5A5A5, 1'b1};

    // Reset, with a command and bus activity present the whole time.
    reset = 1'b1; cpu_req = 1'b1; cpu_addr = 30'h3; cpu_rw = 1'b1;
    cpu_wr_data = 32'hFFFF; m_grnt = 1'b1; s_rdy = 1'b1; s_rd_data = 32'h77;
    repeat (3) @(negedge clk);
    check("reset ctrl", 64'({cpu_busy, cpu_done, cpu_err, m_req, m_as, m_rw}), 64'(0));
    check("reset addr", 64'(m_addr), 64'(0));
    check("reset wdata", 64'(m_wr_data), 64'(0));
    check("reset rdata", 64'(cpu_rd_data), 64'(0));
    reset = 1'b0; cpu_req = 1'b0; m_grnt = 1'b0; s_rdy = 1'b0;
    @(negedge clk);
    check("idle after reset", 64'({cpu_busy, cpu_done, m_req, m_as}), 64'(0));

    for (int i = 0; i < 5; i++) do_txn(tbl[i], 1'b0, $sformatf("tbl%0d", i));
    model_rd = tbl[4].exp_rd;

    // Back-to-back: cpu_req held, grant and ready held high.
    a1 = 30'h0001234; a2 = 30'h0005678; r1 = 32'h11112222; r2 = 32'h33334444;
    cpu_req = 1'b1; cpu_addr = a1; cpu_rw = 1'b1; m_grnt = 1'b1; s_rdy = 1'b1; s_rd_data = r1;
    req_bits = '0; done_bits = '0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      req_bits[k-1] = m_req; done_bits[k-1] = cpu_done;
      if (k == 1) check("b2b addr1", 64'(m_addr), 64'(a1));
      if (k == 4) check("b2b addr2", 64'(m_addr), 64'(a2));
      if (k == 3) check("b2b rd1", 64'(cpu_rd_data), 64'(r1));
      if (k == 6) check("b2b rd2", 64'(cpu_rd_data), 64'(r2));
      if (k == 1) cpu_addr = a2;
      if (k == 3) s_rd_data = r2;
      if (k == 6) begin cpu_req = 1'b0; m_grnt = 1'b0; s_rdy = 1'b0; end
    end
    check("b2b m_req pattern", 64'(req_bits), 64'(7'b0011011));
    check("b2b done pattern", 64'(done_bits), 64'(7'b0100100));
    model_rd = r2;

    // Reset while in WAIT.
    cpu_req = 1'b1; cpu_addr = 30'h0ABCDE; cpu_rw = 1'b0; cpu_wr_data = 32'h0F0F0F0F;
    m_grnt = 1'b1; s_rdy = 1'b0;
    @(negedge clk); cpu_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("wait req/as", 64'({m_req, m_as}), 64'(2'b10));
    check("wait wdata", 64'(m_wr_data), 64'(32'h0F0F0F0F));
    reset = 1'b1;
    @(negedge clk);
    check("rst_wait ctrl", 64'({cpu_busy, cpu_done, cpu_err, m_req, m_as, m_rw}), 64'(0));
    check("rst_wait bus", 64'({m_addr, m_wr_data}), 64'(0));
    check("rst_wait rdata", 64'(cpu_rd_data), 64'(0));
    reset = 1'b0; m_grnt = 1'b0; s_rdy = 1'b1;
    @(negedge clk);
    check("rst_wait no done", 64'({cpu_done, cpu_busy, m_req}), 64'(0));
    s_rdy = 1'b0;
    model_rd = '0;
    v = '{addr: 30'h0000777, rw: 1'b1, wd: 32'h0, rd: 32'h600DF00D, req_len: 2, rdl: 1,
          lat: 5, exp_rd: 32'h600DF00D, noise: 1'b0};
    do_txn(v, 1'b0, "post_reset");
    model_rd = v.exp_rd;

`ifdef BUS_TIMEOUT_EN
    v = '{addr: 30'h123, rw: 1'b1, wd: 32'h0, rd: 32'hCAFEF00D, req_len: 1, rdl: 0,
          lat: 1 + 1 + TMO, exp_rd: model_rd, noise: 1'b0};
    do_txn(v, 1'b1, "timeout");
    v = '{addr: 30'h124, rw: 1'b1, wd: 32'h0, rd: 32'hCAFEF00D, req_len: 1, rdl: TMO - 1,
          lat: 2 + 1 + TMO - 1, exp_rd: 32'hCAFEF00D, noise: 1'b0};
    do_txn(v, 1'b0, "timeout_edge");
    model_rd = v.exp_rd;
`endif

    // Random transactions against the latency/data rules.
    for (int i = 0; i < 40; i++) begin
      v.addr = ADDR_W'($urandom); v.rw = 1'($urandom);
      v.wd = $urandom; v.rd = $urandom;
      v.req_len = $urandom_range(1, 5); v.rdl = $urandom_range(0, RDL_MAX);
      v.noise = 1'($urandom);
      tmo = 1'b0;
`ifdef BUS_TIMEOUT_EN
      tmo = ($urandom_range(0, 7) == 0);
`endif
      if (tmo) begin
        v.lat = v.req_len + 1 + TMO;
        v.exp_rd = model_rd;
      end else begin
        v.lat = 3 + (v.req_len - 1) + v.rdl;
        v.exp_rd = v.rw ? v.rd : model_rd;
      end
      do_txn(v, tmo, $sformatf("rnd%0d", i));
      model_rd = v.exp_rd;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
